// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB2AXI response path.
// Contents: tag/beat/data sizing, completion entry layout (cpl_entry_t,
// MSB->LSB: is_wr, tag, beat, last, resp, data), AXI response codes and
// resp_worst(), which picks the more severe of two response codes.
package apb2axi_pkg;

  localparam int TAG_NUM       = 8;
  localparam int TAG_W         = $clog2(TAG_NUM);
  localparam int MAX_BEATS_NUM = 16;
  localparam int AXI_ID_W      = 4;
  localparam int AXI_DATA_W    = 32;
  localparam int COMPLETION_W  = 1 + TAG_W + $clog2(MAX_BEATS_NUM) + 1 + 2 + AXI_DATA_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic                               is_wr;
    logic [TAG_W-1:0]                   tag;
    logic [$clog2(MAX_BEATS_NUM)-1:0]   beat;
    logic                               last;
    logic [1:0]                         resp;
    logic [AXI_DATA_W-1:0]              data;
  } cpl_entry_t;

  // Response codes are ordered by severity, so the larger code wins.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rsp_rr_arbiter.sv
// Two-requester round-robin arbiter with a single priority bit.
// Ports: clk/rst_n (async active-low), req_a/req_b requests, adv = the
// granted request is actually consumed this cycle, gnt_a/gnt_b grants
// (combinational, one-hot or zero). prio=0 prefers a, prio=1 prefers b.
// Priority only flips on a consumed grant while both were requesting, so a
// stalled consumer never disturbs fairness.
module rsp_rr_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic adv,
  output logic gnt_a,
  output logic gnt_b
);

  logic prio_r;

  always_comb begin
    gnt_a = req_a && (!req_b || !prio_r);
    gnt_b = req_b && !gnt_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       prio_r <= 1'b0;
    else if (adv && req_a && req_b)   prio_r <= gnt_a;
  end

endmodule

// File: rtl/burst_response_collector.sv
// Collects AXI R beats and B responses into completion FIFO entries.
// Ports: aclk/aresetn (async active-low); AXI B (bid, bresp, bvalid, bready);
// AXI R (rid, rdata, rresp, rlast, rvalid, rready); completion push
// (cpl_push_valid, cpl_push_data, cpl_push_ready); err_overrun sticky flag.
// R and B share one registered output stage, arbitrated round-robin. Per tag
// it tracks the beat index and the worst response seen so far in the burst,
// so the last beat carries the burst-aggregate response.
// Optional macro APB2AXI_RSP_PROTO_CHECK_EN: detects bursts longer than
// MAX_BEATS_NUM without rlast, flags err_overrun, forces SLVERR on the
// offending beats and saturates the beat counter. Without it the counter
// wraps and err_overrun is constant 0.
module burst_response_collector
  import apb2axi_pkg::*;
#(
  parameter int TAG_NUM       = apb2axi_pkg::TAG_NUM,
  parameter int TAG_W         = $clog2(TAG_NUM),
  parameter int DATA_W        = apb2axi_pkg::AXI_DATA_W,
  parameter int MAX_BEATS_NUM = apb2axi_pkg::MAX_BEATS_NUM,
  parameter int BEAT_W        = $clog2(MAX_BEATS_NUM),
  parameter int FIFO_W        = 1 + TAG_W + BEAT_W + 1 + 2 + DATA_W
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic                cpl_push_valid,
  output logic [FIFO_W-1:0]   cpl_push_data,
  input  logic                cpl_push_ready,
  output logic                err_overrun
);

  logic                           slot_free, gnt_r, gnt_b, r_acc, b_acc;
  logic                           out_vld;
  logic [FIFO_W-1:0]              out_data;
  logic [TAG_NUM-1:0][BEAT_W-1:0] beat_cnt;
  logic [TAG_NUM-1:0][1:0]        err_acc;
  logic [TAG_W-1:0]               rtag, btag;
  logic [BEAT_W-1:0]              cur_beat, nxt_beat;
  logic [1:0]                     r_resp_w, r_resp;
  logic [FIFO_W-1:0]              r_entry, b_entry;

  // Tags alias to the low ID bits; the upper bits are intentionally dropped.
  assign rtag = rid[TAG_W-1:0];
  assign btag = bid[TAG_W-1:0];

  generate
    if (AXI_ID_W > TAG_W) begin : g_id_hi
      logic unused_id_hi;
      assign unused_id_hi = ^{rid[AXI_ID_W-1:TAG_W], bid[AXI_ID_W-1:TAG_W]};
    end
  endgenerate

  // The output register can take a new entry if empty or being popped now.
  assign slot_free = !out_vld || cpl_push_ready;

  rsp_rr_arbiter u_arb (
    .clk   (aclk),
    .rst_n (aresetn),
    .req_a (rvalid),
    .req_b (bvalid),
    .adv   (slot_free),
    .gnt_a (gnt_r),
    .gnt_b (gnt_b)
  );

  assign rready = slot_free && gnt_r;
  assign bready = slot_free && gnt_b;
  assign r_acc  = rvalid && rready;
  assign b_acc  = bvalid && bready;

  assign cur_beat = beat_cnt[rtag];
  assign r_resp_w = resp_worst(err_acc[rtag], rresp);

`ifdef APB2AXI_RSP_PROTO_CHECK_EN
  logic ovr, err_ovr_r;

  // A non-last beat arriving when the counter already sits at the final
  // index means the burst is longer than any legal burst.
  assign ovr      = !rlast && (cur_beat == BEAT_W'(MAX_BEATS_NUM - 1));
  assign r_resp   = ovr ? RESP_SLVERR : r_resp_w;
  assign nxt_beat = ovr ? cur_beat : cur_beat + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)         err_ovr_r <= 1'b0;
    else if (r_acc && ovr) err_ovr_r <= 1'b1;
  end

  assign err_overrun = err_ovr_r;
`else
  assign r_resp      = r_resp_w;
  assign nxt_beat    = cur_beat + 1'b1;
  assign err_overrun = 1'b0;
`endif

  assign r_entry = {1'b0, rtag, cur_beat, rlast, r_resp, rdata};
  assign b_entry = {1'b1, btag, {BEAT_W{1'b0}}, 1'b1, bresp, {DATA_W{1'b0}}};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < TAG_NUM; i++) begin
        beat_cnt[i] <= '0;
        err_acc[i]  <= '0;
      end
    end else if (r_acc) begin
      if (rlast) begin
        beat_cnt[rtag] <= '0;
        err_acc[rtag]  <= '0;
      end else begin
        beat_cnt[rtag] <= nxt_beat;
        err_acc[rtag]  <= r_resp;
      end
    end
  end

  // Single output stage: reloads in the same cycle it is popped.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (slot_free) begin
      out_vld <= r_acc || b_acc;
      if (b_acc)      out_data <= b_entry;
      else if (r_acc) out_data <= r_entry;
    end
  end

  assign cpl_push_valid = out_vld;
  assign cpl_push_data  = out_data;

endmodule

// File: tb/tb_burst_response_collector.sv
// Scoreboard bench for burst_response_collector: stimulus tasks push the
// hand-computed completion entry into a queue; a negedge monitor pops and
// compares whenever an entry is pushed into the FIFO.
module tb_burst_response_collector;
  import apb2axi_pkg::*;

  localparam int FW = COMPLETION_W;

  logic                  aclk, aresetn;
  logic [AXI_ID_W-1:0]   bid, rid;
  logic [1:0]            bresp, rresp;
  logic                  bvalid, bready, rvalid, rready, rlast;
  logic [AXI_DATA_W-1:0] rdata;
  logic                  cpl_push_valid, cpl_push_ready, err_overrun;
  logic [FW-1:0]         cpl_push_data;

  int errors = 0;
  int checks = 0;
  logic [FW-1:0] expq[$];

  burst_response_collector dut (
    .aclk(aclk), .aresetn(aresetn),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .cpl_push_valid(cpl_push_valid), .cpl_push_data(cpl_push_data),
    .cpl_push_ready(cpl_push_ready), .err_overrun(err_overrun)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input bit w, input int tag, input int beat, input bit l,
                                       input logic [1:0] rs, input logic [31:0] d);
    cpl_entry_t e;
    e.is_wr = w;
    e.tag   = TAG_W'(tag);
    e.beat  = 4'(beat);
    e.last  = l;
    e.resp  = rs;
    e.data  = d;
    return e;
  endfunction

  // Monitor: every entry leaving the output stage must match the queue head.
  always @(negedge aclk) begin
    if (aresetn && cpl_push_valid && cpl_push_ready) begin
      if (expq.size() == 0) chk("unexpected_entry", 64'(cpl_push_data), 64'hdead);
      else                  chk("entry", 64'(cpl_push_data), 64'(expq.pop_front()));
    end
  end

  // Drive one R beat and hold it until accepted; pushes its expected entry.
  task automatic rb(input logic [3:0] id, input logic [31:0] d, input logic [1:0] rs, input bit l,
                    input int etag, input int ebeat, input logic [1:0] eresp, input bit push);
    int n = 0;
    bit ok = 0;
    if (push) expq.push_back(mk(0, etag, ebeat, l, eresp, d));
    rid = id; rdata = d; rresp = rs; rlast = l; rvalid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge aclk);
      if (rready) ok = 1;
      n++;
    end
    if (!ok) chk("r_handshake_timeout", 0, 1);
    @(posedge aclk); #1;
    rvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (expq.size() != 0) chk("drain_timeout", 64'(expq.size()), 0);
    @(posedge aclk); #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, 64'(cpl_push_valid), 0);
    chk({name, "_data"},  64'(cpl_push_data), 0);
    chk({name, "_rready"}, 64'(rready), 0);
    chk({name, "_bready"}, 64'(bready), 0);
    chk({name, "_ovr"},   64'(err_overrun), 0);
  endtask

  initial begin
    logic [FW-1:0] held;
    logic [3:0] exp_r;
    int rc, bc;
    aresetn = 1'b0;
    bid = '0; bresp = '0; bvalid = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    cpl_push_ready = 1'b1;
    #12;
    chk_idle("reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single burst, ID 3, 4 OKAY beats.
    for (int i = 0; i < 4; i++)
      rb(4'd3, 32'hA0 + 32'(i), RESP_OKAY, i == 3, 3, i, RESP_OKAY, 1);
    drain();

    // Error accumulation then clear: 00,10,00 -> 00,10,10; next burst on tag 1 starts clean.
    rb(4'd1, 32'h10, 2'b00, 0, 1, 0, 2'b00, 1);
    rb(4'd1, 32'h11, 2'b10, 0, 1, 1, 2'b10, 1);
    rb(4'd1, 32'h12, 2'b00, 1, 1, 2, 2'b10, 1);
    rb(4'd1, 32'h13, 2'b00, 1, 1, 0, 2'b00, 1);
    drain();
    chk("no_ovr_default", 64'(err_overrun), 0);

    // R and B both valid: grants R,B,R,B.
    expq.push_back(mk(0, 2, 0, 0, 2'b00, 32'h21));
    expq.push_back(mk(1, 5, 0, 1, 2'b00, 32'h0));
    expq.push_back(mk(0, 2, 1, 1, 2'b00, 32'h22));
    expq.push_back(mk(1, 3, 0, 1, 2'b10, 32'h0));
    rid = 4'd2; rdata = 32'h21; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b1;
    bid = 4'hD; bresp = 2'b00; bvalid = 1'b1;
    exp_r = 4'b0101;
    rc = 0; bc = 0;
    for (int c = 0; c < 4; c++) begin
      bit gr, gb;
      @(negedge aclk);
      gr = rready; gb = bready;
      chk("arb_rready", 64'(gr), 64'(exp_r[c]));
      chk("arb_bready", 64'(gb), 64'(!exp_r[c]));
      @(posedge aclk); #1;
      if (gr) begin
        rc++;
        if (rc == 1) begin rdata = 32'h22; rlast = 1'b1; end
        else rvalid = 1'b0;
      end
      if (gb) begin
        bc++;
        if (bc == 1) begin bid = 4'd3; bresp = 2'b10; end
        else bvalid = 1'b0;
      end
    end
    rvalid = 1'b0; bvalid = 1'b0;
    chk("arb_r_count", 64'(rc), 2);
    chk("arb_b_count", 64'(bc), 2);
    drain();

    // Backpressure: FIFO stalls 5 cycles mid-burst.
    fork
      begin
        for (int i = 0; i < 4; i++)
          rb(4'd7, 32'hB0 + 32'(i), RESP_OKAY, i == 3, 7, i, RESP_OKAY, 1);
      end
      begin
        repeat (2) @(posedge aclk);
        #1 cpl_push_ready = 1'b0;
        @(negedge aclk);
        held = cpl_push_data;
        chk("stall_valid", 64'(cpl_push_valid), 1);
        for (int c = 0; c < 4; c++) begin
          @(negedge aclk);
          chk("stall_hold", 64'(cpl_push_data), 64'(held));
          chk("stall_rready", 64'(rready), 0);
          chk("stall_valid", 64'(cpl_push_valid), 1);
        end
        @(posedge aclk); #1 cpl_push_ready = 1'b1;
      end
    join
    drain();

    // Interleaved tags 0 (via aliased ID 8) and 2.
    rb(4'd8, 32'hC0, RESP_OKAY, 0, 0, 0, RESP_OKAY, 1);
    rb(4'd2, 32'hC2, RESP_OKAY, 0, 2, 0, RESP_OKAY, 1);
    rb(4'd0, 32'hC1, RESP_OKAY, 1, 0, 1, RESP_OKAY, 1);
    rb(4'd2, 32'hC3, RESP_OKAY, 1, 2, 1, RESP_OKAY, 1);
    drain();

`ifdef APB2AXI_RSP_PROTO_CHECK_EN
    // 17 beats without rlast: entries 16 and 17 flagged SLVERR at beat 15.
    for (int i = 0; i < 17; i++)
      rb(4'd6, 32'hD0 + 32'(i), RESP_OKAY, 0, 6, (i < 15) ? i : 15,
         (i < 15) ? RESP_OKAY : RESP_SLVERR, 1);
    drain();
    chk("overrun_flag", 64'(err_overrun), 1);
`endif

    // Reset mid-burst: pending entry dropped, tag 4 restarts at beat 0.
    rb(4'd4, 32'hE0, RESP_OKAY, 0, 4, 0, RESP_OKAY, 1);
    rb(4'd4, 32'hE1, RESP_OKAY, 0, 4, 1, RESP_OKAY, 1);
    drain();
    cpl_push_ready = 1'b0;
    rb(4'd4, 32'hE2, RESP_SLVERR, 0, 4, 2, RESP_SLVERR, 0);
    chk("pre_reset_pending", 64'(cpl_push_valid), 1);
    aresetn = 1'b0;
    #2;
    chk_idle("midreset");
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    cpl_push_ready = 1'b1;
    rb(4'd4, 32'hE3, RESP_OKAY, 1, 4, 0, RESP_OKAY, 1);
    drain();
    chk("queue_empty", 64'(expq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/burst_response_collector.md
# burst_response_collector

Parametrised successor of the APB2AXI response collector. It owns the AXI R and B ready signals and arbitrates round-robin between the two channels. It tracks per-tag beat index and accumulated burst error, and pushes one completion entry per accepted beat or write response into the completion FIFO, through a single registered output stage. It sits between the AXI master port and the completion FIFO, on the AXI clock domain.

## Interface
Parameters:
- TAG_NUM, default TAG_NUM (pkg): number of outstanding tags; tag = low TAG_W bits of the AXI ID.
- TAG_W, default TAG_W (pkg): tag width, equal to $clog2(TAG_NUM).
- DATA_W, default AXI_DATA_W (pkg): R data width carried in the entry.
- MAX_BEATS_NUM, default MAX_BEATS_NUM (pkg): maximum burst length (16 for AXI3).
- BEAT_W, default $clog2(MAX_BEATS_NUM): beat index width.
- FIFO_W, default COMPLETION_W (pkg): entry width, equal to 1+TAG_W+BEAT_W+1+2+DATA_W.

Ports:
- aclk, in, 1: the single clock.
- aresetn, in, 1: reset, asynchronous, active-low.
- bid, in, AXI_ID_W: write response ID.
- bresp, in, 2: write response code.
- bvalid, in, 1: B valid.
- bready, out, 1: B ready.
- rid, in, AXI_ID_W: read ID.
- rdata, in, DATA_W: read data.
- rresp, in, 2: read response code.
- rlast, in, 1: last beat of the burst.
- rvalid, in, 1: R valid.
- rready, out, 1: R ready.
- cpl_push_valid, out, 1: completion entry valid.
- cpl_push_data, out, FIFO_W: completion entry.
- cpl_push_ready, in, 1: completion FIFO can accept.
- err_overrun, out, 1: sticky flag, protocol check (see Configuration).

## Operation
- Entry layout, MSB to LSB: is_wr, tag, beat, last, resp, data.
- B entry: is_wr=1, tag=bid[TAG_W-1:0], beat=0, last=1, resp=bresp, data=0.
- R entry: is_wr=0, tag=rid[TAG_W-1:0], beat=beat_cnt[tag], last=rlast, resp=worst(err_acc[tag], rresp), data=rdata.
- worst() returns the numerically larger code: DECERR(11) > SLVERR(10) > EXOKAY(01) > OKAY(00).
  - The last beat therefore carries the burst-aggregate response.
- Per-tag state arrays: beat_cnt[TAG_NUM] (BEAT_W bits) and err_acc[TAG_NUM] (2 bits).
  - On R accept with rlast=0: beat_cnt increments and err_acc takes the worst() result.
  - On R accept with rlast=1: both clear to 0.
- Slot free: slot_free = !cpl_push_valid || cpl_push_ready.
- Arbiter: a single priority bit, prio_r, with reset value 0 (R preferred).
  - Grant R when rvalid && (!bvalid || !prio_r). Otherwise grant B when bvalid.
  - On both-valid grant, prio_r flips to the other channel. A single-requester grant leaves prio_r unchanged.
- Ready outputs: rready = slot_free && grant_r; bready = slot_free && grant_b. At most one is ever high.
- The non-granted channel's valid/payload must be held by the AXI slave (AXI rule). The block never drops a beat.
- Tags wrap: an ID with bits above TAG_W is aliased to its low bits. Software guarantees uniqueness.

## Timing
- Reset values: cpl_push_valid=0, cpl_push_data=0, rready=0, bready=0, err_overrun=0. All beat_cnt and err_acc are 0, prio_r=0.
- Latency: 1 cycle. A channel handshake in cycle N gives cpl_push_valid=1 with that entry in cycle N+1.
- Throughput: 1 entry/cycle while cpl_push_ready=1.
- Backpressure: while cpl_push_valid && !cpl_push_ready, the entry holds stable and rready=bready=0.
- Same-cycle pop and push (ready=1 with a new grant): the output register reloads with no bubble.
- Reset mid-burst: all per-tag state is lost. The following beats of that burst start at beat 0. The pending output entry is discarded.
- rready and bready are combinational from valid, cpl_push_valid, cpl_push_ready and prio_r. There is no combinational path from data to ready.

## Configuration
- `APB2AXI_RSP_PROTO_CHECK_EN` defined:
  - An R beat accepted with beat_cnt[tag] == MAX_BEATS_NUM-1 and rlast=0 sets err_overrun (sticky until reset).
  - That beat is pushed with resp forced to SLVERR, and the counter saturates.
- Not defined: err_overrun is tied to 0, no saturation logic exists, and the counter wraps modulo 2^BEAT_W.

## Structure
- apb2axi_pkg holds: TAG_NUM, TAG_W, MAX_BEATS_NUM, AXI_ID_W, AXI_DATA_W, COMPLETION_W, the packed struct cpl_entry_t (field order above), and resp-code localparams RESP_OKAY/EXOKAY/SLVERR/DECERR.
- One sub-module: rsp_rr_arbiter, a 2-requester round-robin with a prio bit, reusable for other channel pairs.

## Test plan
- Single read burst, ID 3, 4 beats, all OKAY, data 0xA0..0xA3 -> 4 entries: tag=3, beat 0..3, last only on beat 3, resp 00.
- Read burst, ID 1, 3 beats with rresp 00,10,00 -> entry resp values 00,10,10. err_acc[1]=0 afterwards.
- rvalid and bvalid held together for 4 cycles, FIFO always ready -> grants alternate R,B,R,B. Each channel sees exactly two handshakes.
- cpl_push_ready=0 for 5 cycles during a burst -> entry held stable, rready=0, no beat lost. All beats emerge in order once ready returns.
- Interleaved tags 0 and 2 (beats 0a,2a,0b,2b) -> beat indices per tag are 0,0,1,1.
- With APB2AXI_RSP_PROTO_CHECK_EN: 17 beats with no rlast at MAX_BEATS_NUM=16 -> the 16th and 17th entries have resp 10, beat=15, and err_overrun=1. Asserting aresetn low mid-burst returns all outputs to 0.
